// File: rtl/ifetch_align.sv
// ---------------------------------------------------------------------------
// ifetch_align -- instruction-fetch front end for the RV32EMC core.
//
// Reads halfwords from the read-only port of the instruction/data RAM,
// buffers them in a small prefetch FIFO and realigns them into 16-bit (RVC)
// or 32-bit instructions for the decoder. A redirect flushes everything
// fetched so far and restarts fetch at the new target.
//
// Configuration macro:
//   IFETCH_BYPASS_EN  when defined, the halfword returning from the RAM this
//                     cycle is visible to the output decode as a virtual FIFO
//                     tail. This saves one cycle of latency after a redirect
//                     or underrun. When undefined, every halfword passes
//                     through the FIFO first.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset (overrides redirect)
//   redirect     one-cycle pulse, restart fetch at redirect_pc
//   redirect_pc  byte target of the redirect (bit 0 ignored)
//   mem_en       RAM read enable
//   mem_addr     RAM halfword address
//   mem_dout     RAM read data, valid the cycle after mem_en
//   inst_valid   inst / inst_pc / inst_rvc are valid
//   inst_ready   decoder accepts the presented instruction
//   inst         instruction, RVC zero-extended in bits 31:16
//   inst_pc      byte address of inst
//   inst_rvc     1 = 16-bit instruction
// ---------------------------------------------------------------------------
module ifetch_align #(
  parameter int                  ADDR_WIDTH = 13,
  parameter logic [ADDR_WIDTH:0] RESET_PC   = {(ADDR_WIDTH+1){1'b0}},
  parameter int                  FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH:0]   redirect_pc,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [15:0]           mem_dout,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [31:0]           inst,
  output logic [ADDR_WIDTH:0]   inst_pc,
  output logic                  inst_rvc
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 1;
  // Clears bit 0 of a byte PC so it always points at a halfword.
  localparam logic [ADDR_WIDTH:0] PC_MASK = {{ADDR_WIDTH{1'b1}}, 1'b0};

  // Prefetch buffer and fetch state
  logic [15:0]           fifoMem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]      rdPtr_r;
  logic [PTR_W-1:0]      wrPtr_r;
  logic [CNT_W-1:0]      count_r;
  logic                  pend_r;
  logic [ADDR_WIDTH-1:0] fa_r;
  logic [ADDR_WIDTH:0]   headPc_r;

  // Combinational control
  logic [SUM_W-1:0]      inFlight_s;
  logic                  issue_s;
  logic [15:0]           h0_s;
  logic [15:0]           h1_s;
  logic [SUM_W-1:0]      avail_s;
  logic                  isRvc_s;
  logic                  instValid_s;
  logic                  pop_s;
  logic [1:0]            popN_s;
  logic [1:0]            fifoPopN_s;
  logic                  doutConsumed_s;
  logic                  push_s;

  // Read issue: buffered plus in-flight halfwords never exceed the FIFO
  // capacity, so a returning halfword always has a free slot.
  always_comb begin
    inFlight_s = {1'b0, count_r} + SUM_W'(pend_r);
    issue_s    = 1'b0;
    if (rst || redirect) begin
      issue_s = 1'b0;
    end else begin
      issue_s = (inFlight_s < SUM_W'(FIFO_DEPTH));
    end
  end

  // Head/next halfword selection and number of halfwords available to decode
  always_comb begin
    h0_s    = fifoMem_r[rdPtr_r];
    h1_s    = fifoMem_r[rdPtr_r + PTR_W'(1)];
    avail_s = {1'b0, count_r};
`ifdef IFETCH_BYPASS_EN
    // The returning halfword sits logically just behind the buffered ones.
    avail_s = inFlight_s;
    if (count_r == CNT_W'(0)) begin
      h0_s = mem_dout;
    end else begin
      h0_s = fifoMem_r[rdPtr_r];
    end
    if (count_r < CNT_W'(2)) begin
      h1_s = mem_dout;
    end else begin
      h1_s = fifoMem_r[rdPtr_r + PTR_W'(1)];
    end
`endif
  end

  // Instruction length decode and handshake
  always_comb begin
    isRvc_s = (h0_s[1:0] != 2'b11);
    if (isRvc_s) begin
      instValid_s = (avail_s >= SUM_W'(1));
      popN_s      = 2'd1;
    end else begin
      instValid_s = (avail_s >= SUM_W'(2));
      popN_s      = 2'd2;
    end
    // A redirect discards the buffer, so nothing is consumed in that cycle.
    pop_s = instValid_s && inst_ready && !redirect;
  end

  // Split the pop between FIFO entries and the returning halfword
  always_comb begin
    doutConsumed_s = 1'b0;
    fifoPopN_s     = 2'd0;
    if (!pop_s) begin
      fifoPopN_s     = 2'd0;
      doutConsumed_s = 1'b0;
    end else begin
`ifdef IFETCH_BYPASS_EN
      // Popping more than is buffered means the last halfword came straight
      // from mem_dout; it must then not be pushed as well.
      if (SUM_W'(popN_s) > {1'b0, count_r}) begin
        doutConsumed_s = 1'b1;
        fifoPopN_s     = popN_s - 2'd1;
      end else begin
        doutConsumed_s = 1'b0;
        fifoPopN_s     = popN_s;
      end
`else
      doutConsumed_s = 1'b0;
      fifoPopN_s     = popN_s;
`endif
    end
    push_s = pend_r && !doutConsumed_s;
  end

  // Output drive; RVC instructions are zero-extended
  always_comb begin
    mem_en     = issue_s;
    mem_addr   = fa_r;
    inst_valid = instValid_s;
    inst_pc    = headPc_r;
    inst_rvc   = isRvc_s;
    if (isRvc_s) begin
      inst = {16'h0000, h0_s};
    end else begin
      inst = {h1_s, h0_s};
    end
  end

  // Prefetch buffer storage (contents need no reset, the count qualifies them)
  always_ff @(posedge clk) begin
    if (!rst && !redirect && push_s) begin
      fifoMem_r[wrPtr_r] <= mem_dout;
    end
  end

  // Fetch pointer, pending-read flag, FIFO pointers and head PC
  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr_r  <= {PTR_W{1'b0}};
      wrPtr_r  <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      pend_r   <= 1'b0;
      fa_r     <= RESET_PC[ADDR_WIDTH:1];
      headPc_r <= RESET_PC & PC_MASK;
    end else if (redirect) begin
      // Flush; the read returning next cycle is dropped because pend clears.
      rdPtr_r  <= {PTR_W{1'b0}};
      wrPtr_r  <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      pend_r   <= 1'b0;
      fa_r     <= redirect_pc[ADDR_WIDTH:1];
      headPc_r <= redirect_pc & PC_MASK;
    end else begin
      pend_r <= issue_s;
      if (issue_s) begin
        fa_r <= fa_r + ADDR_WIDTH'(1);
      end
      if (push_s) begin
        wrPtr_r <= wrPtr_r + PTR_W'(1);
      end
      rdPtr_r <= rdPtr_r + PTR_W'(fifoPopN_s);
      count_r <= count_r + CNT_W'(push_s) - CNT_W'(fifoPopN_s);
      if (pop_s) begin
        if (isRvc_s) begin
          headPc_r <= headPc_r + (ADDR_WIDTH+1)'(2);
        end else begin
          headPc_r <= headPc_r + (ADDR_WIDTH+1)'(4);
        end
      end
    end
  end

endmodule

// File: tb/tb_ifetch_align.sv
// Directed self-checking bench for ifetch_align (default parameters).
module tb_ifetch_align;
  localparam int AW = 13;
`ifdef IFETCH_BYPASS_EN
  localparam int REDIR_LAT = 2;
`else
  localparam int REDIR_LAT = 3;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          redirect;
  logic [AW:0]   redirect_pc;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_dout = 16'h0000;
  logic          inst_valid;
  logic          inst_ready;
  logic [31:0]   inst;
  logic [AW:0]   inst_pc;
  logic          inst_rvc;

  logic [15:0]   ram [0:(1<<AW)-1];
  int nChecks = 0;
  int nPass   = 0;

  logic [31:0] gInst[$];
  logic [AW:0] gPc[$];
  logic        gRvc[$];
  int          gCyc[$];

  ifetch_align dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .inst_rvc(inst_rvc)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM model, output held while disabled
  always @(posedge clk) begin
    if (mem_en) mem_dout <= ram[mem_addr];
  end

  task automatic clear_ram();
    for (int i = 0; i < (1 << AW); i++) ram[i] = 16'h0000;
  endtask

  // Ends at cycle 0 after reset release (negedge + 1).
  task automatic do_reset(input logic rdy);
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; inst_ready = rdy;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // Record accepted instructions (valid && ready && !redirect) with cycle index.
  task automatic collect(input int n, input int maxCyc);
    gInst.delete(); gPc.delete(); gRvc.delete(); gCyc.delete();
    #1;
    for (int c = 0; c < maxCyc && gInst.size() < n; c++) begin
      if (inst_valid && inst_ready && !redirect) begin
        gInst.push_back(inst); gPc.push_back(inst_pc);
        gRvc.push_back(inst_rvc); gCyc.push_back(c);
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b1; redirect_pc = 14'h0100; inst_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    nChecks++; if (mem_en !== 1'b0) $display("FAIL reset_mem_en: got %0b want 0", mem_en); else nPass++;
    nChecks++; if (inst_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", inst_valid); else nPass++;
    nChecks++; if (mem_addr !== 13'h0000) $display("FAIL reset_addr: got %h want 0000", mem_addr); else nPass++;
    nChecks++; if (inst_pc !== 14'h0000) $display("FAIL reset_pc: got %h want 0000", inst_pc); else nPass++;
    redirect = 1'b0;
  endtask

  task automatic test_32bit();
    logic [31:0] expI [2] = '{32'h00000013, 32'h00100093};
    logic [AW:0] expP [2] = '{14'h0000, 14'h0004};
    clear_ram();
    ram[0] = 16'h0013; ram[1] = 16'h0000; ram[2] = 16'h0093; ram[3] = 16'h0010;
    do_reset(1'b1);
    collect(2, 30);
    for (int i = 0; i < 2; i++) begin
      nChecks++;
      if (i >= gInst.size()) $display("FAIL w32_inst%0d: got none want %h", i, expI[i]);
      else if (gInst[i] !== expI[i]) $display("FAIL w32_inst%0d: got %h want %h", i, gInst[i], expI[i]);
      else nPass++;
      nChecks++;
      if (i >= gPc.size()) $display("FAIL w32_pc%0d: got none want %h", i, expP[i]);
      else if (gPc[i] !== expP[i]) $display("FAIL w32_pc%0d: got %h want %h", i, gPc[i], expP[i]);
      else nPass++;
      nChecks++;
      if (i >= gRvc.size()) $display("FAIL w32_rvc%0d: got none want 0", i);
      else if (gRvc[i] !== 1'b0) $display("FAIL w32_rvc%0d: got %0b want 0", i, gRvc[i]);
      else nPass++;
    end
  endtask

  task automatic test_mixed();
    logic [31:0] expI [3] = '{32'h00004501, 32'h00a00593, 32'h00004505};
    logic [AW:0] expP [3] = '{14'h0000, 14'h0002, 14'h0006};
    logic        expR [3] = '{1'b1, 1'b0, 1'b1};
    clear_ram();
    ram[0] = 16'h4501; ram[1] = 16'h0593; ram[2] = 16'h00a0; ram[3] = 16'h4505;
    do_reset(1'b1);
    collect(3, 30);
    for (int i = 0; i < 3; i++) begin
      nChecks++;
      if (i >= gInst.size()) $display("FAIL mix_inst%0d: got none want %h", i, expI[i]);
      else if (gInst[i] !== expI[i]) $display("FAIL mix_inst%0d: got %h want %h", i, gInst[i], expI[i]);
      else nPass++;
      nChecks++;
      if (i >= gPc.size()) $display("FAIL mix_pc%0d: got none want %h", i, expP[i]);
      else if (gPc[i] !== expP[i]) $display("FAIL mix_pc%0d: got %h want %h", i, gPc[i], expP[i]);
      else nPass++;
      nChecks++;
      if (i >= gRvc.size()) $display("FAIL mix_rvc%0d: got none want %0b", i, expR[i]);
      else if (gRvc[i] !== expR[i]) $display("FAIL mix_rvc%0d: got %0b want %0b", i, gRvc[i], expR[i]);
      else nPass++;
    end
  endtask

  task automatic test_stall();
    logic [31:0] expI [5] = '{32'h00000013, 32'h00100093, 32'h00004501, 32'h00a00593, 32'h00004505};
    logic [AW:0] expP [5] = '{14'h0000, 14'h0004, 14'h0008, 14'h000a, 14'h000e};
    int enCnt = 0;
    int bad   = 0;
    clear_ram();
    ram[0] = 16'h0013; ram[1] = 16'h0000; ram[2] = 16'h0093; ram[3] = 16'h0010;
    ram[4] = 16'h4501; ram[5] = 16'h0593; ram[6] = 16'h00a0; ram[7] = 16'h4505;
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) begin
      if (mem_en) enCnt++;
      if (inst_valid && (inst !== 32'h00000013 || inst_pc !== 14'h0000)) bad++;
      @(negedge clk); #1;
    end
    nChecks++; if (enCnt !== 4) $display("FAIL stall_reads: got %0d want 4", enCnt); else nPass++;
    nChecks++; if (mem_addr !== 13'h0004) $display("FAIL stall_addr: got %h want 0004", mem_addr); else nPass++;
    nChecks++; if (inst_valid !== 1'b1) $display("FAIL stall_valid: got %0b want 1", inst_valid); else nPass++;
    nChecks++; if (bad !== 0) $display("FAIL stall_stable: got %0d unstable cycles want 0", bad); else nPass++;
    inst_ready = 1'b1;
    collect(5, 40);
    for (int i = 0; i < 5; i++) begin
      nChecks++;
      if (i >= gInst.size()) $display("FAIL stall_inst%0d: got none want %h", i, expI[i]);
      else if (gInst[i] !== expI[i]) $display("FAIL stall_inst%0d: got %h want %h", i, gInst[i], expI[i]);
      else nPass++;
      nChecks++;
      if (i >= gPc.size()) $display("FAIL stall_pc%0d: got none want %h", i, expP[i]);
      else if (gPc[i] !== expP[i]) $display("FAIL stall_pc%0d: got %h want %h", i, gPc[i], expP[i]);
      else nPass++;
    end
  endtask

  task automatic test_redirect();
    clear_ram();
    for (int i = 0; i < 16; i++) ram[i] = 16'h0001;
    ram[13'h081] = 16'h0513; ram[13'h082] = 16'h0040;
    do_reset(1'b1);
    repeat (5) begin @(negedge clk); #1; end
    nChecks++; if (mem_addr !== 13'h0005 || mem_en !== 1'b1) $display("FAIL redir_pre: got addr %h en %0b want 0005 1", mem_addr, mem_en); else nPass++;
    @(negedge clk); redirect = 1'b1; redirect_pc = 14'h0102; #1;
    nChecks++; if (mem_en !== 1'b0) $display("FAIL redir_en_T: got %0b want 0", mem_en); else nPass++;
    @(negedge clk); redirect = 1'b0; #1;
    nChecks++; if (mem_addr !== 13'h0081) $display("FAIL redir_addr_T1: got %h want 0081", mem_addr); else nPass++;
    nChecks++; if (mem_en !== 1'b1) $display("FAIL redir_en_T1: got %0b want 1", mem_en); else nPass++;
    nChecks++; if (inst_valid !== 1'b0) $display("FAIL redir_valid_T1: got %0b want 0", inst_valid); else nPass++;
    collect(1, 20);
    nChecks++;
    if (gInst.size() < 1) $display("FAIL redir_inst: got none want 00400513");
    else if (gInst[0] !== 32'h00400513 || gPc[0] !== 14'h0102 || gRvc[0] !== 1'b0)
      $display("FAIL redir_inst: got %h @%h rvc %0b want 00400513 @0102 rvc 0", gInst[0], gPc[0], gRvc[0]);
    else nPass++;
  endtask

  task automatic test_wrap();
    clear_ram();
    ram[13'h1FFF] = 16'h0513; ram[0] = 16'h0000; ram[1] = 16'h4505;
    do_reset(1'b0);
    @(negedge clk); redirect = 1'b1; redirect_pc = 14'h3FFE; #1;
    @(negedge clk); redirect = 1'b0; inst_ready = 1'b1; #1;
    nChecks++; if (mem_addr !== 13'h1FFF) $display("FAIL wrap_addr: got %h want 1fff", mem_addr); else nPass++;
    collect(2, 30);
    nChecks++;
    if (gInst.size() < 1) $display("FAIL wrap_first: got none want 00000513 @3ffe");
    else if (gInst[0] !== 32'h00000513 || gPc[0] !== 14'h3FFE || gRvc[0] !== 1'b0)
      $display("FAIL wrap_first: got %h @%h rvc %0b want 00000513 @3ffe rvc 0", gInst[0], gPc[0], gRvc[0]);
    else nPass++;
    nChecks++;
    if (gInst.size() < 2) $display("FAIL wrap_second: got none want 00004505 @0002");
    else if (gInst[1] !== 32'h00004505 || gPc[1] !== 14'h0002 || gRvc[1] !== 1'b1)
      $display("FAIL wrap_second: got %h @%h rvc %0b want 00004505 @0002 rvc 1", gInst[1], gPc[1], gRvc[1]);
    else nPass++;
  endtask

  task automatic test_redirect_latency();
    int          first = -1;
    logic [31:0] capInst = 32'h0;
    logic [AW:0] capPc = '0;
    clear_ram();
    ram[13'h040] = 16'h4501;
    do_reset(1'b0);
    repeat (6) begin @(negedge clk); #1; end
    @(negedge clk); redirect = 1'b1; redirect_pc = 14'h0080; #1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); redirect = 1'b0; #1;
      if (first < 0 && inst_valid) begin
        first = k; capInst = inst; capPc = inst_pc;
      end
    end
    nChecks++; if (first !== REDIR_LAT) $display("FAIL lat_cycle: got T+%0d want T+%0d", first, REDIR_LAT); else nPass++;
    nChecks++; if (capInst !== 32'h00004501) $display("FAIL lat_inst: got %h want 00004501", capInst); else nPass++;
    nChecks++; if (capPc !== 14'h0080) $display("FAIL lat_pc: got %h want 0080", capPc); else nPass++;
  endtask

  task automatic test_back_to_back();
    clear_ram();
    for (int i = 0; i < 16; i++) ram[i] = 16'((i << 2) | 1);
    do_reset(1'b1);
    collect(10, 60);
    nChecks++; if (gInst.size() !== 10) $display("FAIL b2b_count: got %0d want 10", gInst.size()); else nPass++;
    for (int i = 0; i < 10; i++) begin
      nChecks++;
      if (i >= gInst.size()) $display("FAIL b2b_inst%0d: got none want %h", i, 32'((i << 2) | 1));
      else if (gInst[i] !== 32'((i << 2) | 1) || gPc[i] !== 14'(2 * i))
        $display("FAIL b2b_inst%0d: got %h @%h want %h @%h", i, gInst[i], gPc[i], 32'((i << 2) | 1), 14'(2 * i));
      else nPass++;
    end
    nChecks++;
    if (gCyc.size() < 10) $display("FAIL b2b_rate: got too few accepts want 10");
    else if (gCyc[9] - gCyc[1] !== 8) $display("FAIL b2b_rate: got %0d cycles want 8", gCyc[9] - gCyc[1]);
    else nPass++;
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    clear_ram();
    test_reset();
    test_32bit();
    test_mixed();
    test_stall();
    test_redirect();
    test_wrap();
    test_redirect_latency();
    test_back_to_back();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
